// File: rtl/noise_seq_pkg.sv
// Shared types and constants for the noise-select sequencer.
package noise_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_ON  = 2'd1,
    ON      = 2'd2,
    ARM_OFF = 2'd3
  } state_t;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_BURST  = 1'b1;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes the active-low key, debounces it with a stable counter and emits
// a one-cycle pulse on every debounced press (1 -> 0).
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r <= 1'b1;
      cnt_r   <= '0;
      press   <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r <= '0;
      press <= 1'b0;
    end else if (cnt_r == LAST) begin
      level_r <= sync2_r;
      cnt_r   <= '0;
      press   <= ~sync2_r;
    end else begin
      cnt_r <= cnt_r + CW'(1);
      press <= 1'b0;
    end
  end

endmodule

// File: rtl/noise_sequencer.sv
// Drives the noise-select line of the audio mux from a debounced key, in toggle
// or fixed-length burst mode, switching only on sample boundaries.
module noise_sequencer
  import noise_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             key_n,
  input  logic             mode,
  input  logic [CNT_W-1:0] burst_len,
  output logic             noise_on,
  output logic             busy,
  output logic [CNT_W-1:0] samples_left
);

  state_t           state_r, state_s;
  logic             mode_r, mode_s;
  logic [CNT_W-1:0] len_r, len_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             noise_s;
  logic             press_s;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .press (press_s)
  );

  // Next-state and datapath decisions; a tick beats a press while arming, a press beats a tick in burst ON.
  always_comb begin
    state_s = state_r;
    mode_s  = mode_r;
    len_s   = len_r;
    count_s = count_r;
    noise_s = noise_on;
    case (state_r)
      IDLE: begin
        noise_s = 1'b0;
        if (press_s) begin
          mode_s  = mode;
          len_s   = burst_len;
          state_s = ARM_ON;
        end else begin
          state_s = IDLE;
        end
      end
      ARM_ON: begin
        if (sample_tick) begin
          noise_s = 1'b1;
          count_s = at_least_one(len_r);
          state_s = ON;
        end else if (press_s) begin
          state_s = IDLE;
        end else begin
          state_s = ARM_ON;
        end
      end
      ON: begin
        if (mode_r == MODE_TOGGLE) begin
          if (press_s) begin
            state_s = ARM_OFF;
          end else begin
            state_s = ON;
          end
        end else if (press_s) begin
          count_s = at_least_one(len_r);
        end else if (sample_tick) begin
          if (count_r <= CNT_W'(1)) begin
            count_s = '0;
            noise_s = 1'b0;
            state_s = IDLE;
          end else begin
            count_s = count_r - CNT_W'(1);
          end
        end else begin
          count_s = count_r;
        end
      end
      ARM_OFF: begin
        if (sample_tick) begin
          noise_s = 1'b0;
          state_s = IDLE;
        end else if (press_s) begin
          state_s = ON;
        end else begin
          state_s = ARM_OFF;
        end
      end
      default: begin
        state_s = IDLE;
        noise_s = 1'b0;
        count_s = '0;
      end
    endcase
  end

  // State, latched settings and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      mode_r       <= MODE_TOGGLE;
      len_r        <= '0;
      count_r      <= '0;
      noise_on     <= 1'b0;
      busy         <= 1'b0;
      samples_left <= '0;
    end else begin
      state_r      <= state_s;
      mode_r       <= mode_s;
      len_r        <= len_s;
      count_r      <= count_s;
      noise_on     <= noise_s;
      busy         <= (state_s != IDLE);
      samples_left <= (state_s == ON && mode_s == MODE_BURST) ? count_s : '0;
    end
  end

endmodule
